div_nbits: RTL and testbench

//  Iterative radix-2 restoring divider for the M-extension DIV/DIVU/REM/REMU ops; the inverse of the

---
 rtl/div_nbits.sv | 116 +++++++++++
 tb/tb_div_nbits.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_nbits.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// operands captured on start, results held until the next operation completes.
module div_nbits #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic         kill_i,
  input  logic         signed_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [N-1:0]   rem, quo, dvsr;
  logic           neg_q, neg_r;

  logic           accept, div_zero, overflow, special;
  logic [N-1:0]   abs_a, abs_b;
  logic [N:0]     shifted, diff;
  logic [N-1:0]   q_fix, r_fix;

  // Special cases are decided on the raw operands so no iteration is spent on them.
  assign accept   = start_i && !kill_i;
  assign div_zero = (divisor_i == '0);
  assign overflow = signed_i && (dividend_i == {1'b1, {(N-1){1'b0}}}) && (divisor_i == '1);
  assign special  = div_zero || overflow;

  assign abs_a = (signed_i && dividend_i[N-1]) ? -dividend_i : dividend_i;
  assign abs_b = (signed_i && divisor_i[N-1])  ? -divisor_i  : divisor_i;

  // Trial subtraction in N+1 bits; diff[N] set means the partial remainder was too small.
  assign shifted = {rem, quo[N-1]};
  assign diff    = shifted - {1'b0, dvsr};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (kill_i)             state_next = IDLE;
        else if (count == '0)   state_next = SIGN;
      end
      SIGN: state_next = kill_i ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the datapath registers are reset too; they are few and it keeps outputs defined after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q <= signed_i && (dividend_i[N-1] ^ divisor_i[N-1]);
            neg_r <= signed_i && dividend_i[N-1];
            quo   <= abs_a;
            dvsr  <= abs_b;
            rem   <= '0;
            count <= CW'(N - 1);
            if (div_zero) begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else if (overflow) begin
              quotient_o  <= dividend_i;
              remainder_o <= '0;
            end
          end
        end
        CALC: begin
          rem   <= diff[N] ? shifted[N-1:0] : diff[N-1:0];
          quo   <= {quo[N-2:0], ~diff[N]};
          count <= count - 1'b1;
        end
        SIGN: begin
          if (!kill_i) begin
            quotient_o  <= q_fix;
            remainder_o <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nbits.sv
// Self-checking bench for div_nbits (N=8): a negedge monitor pops a scoreboard of expected
// results and latencies pushed by the stimulus tasks; directed cases cover kill, reset and specials.
module tb_div_nbits;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n, start_i, kill_i, signed_i;
  logic [N-1:0] dividend_i, divisor_i;
  logic         busy_o, valid_o;
  logic [N-1:0] quotient_o, remainder_o;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;

  div_nbits #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .kill_i      (kill_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: language division truncates toward zero, remainder takes the dividend's sign.
  task automatic model(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r, output int lat);
    if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else if (sgn && a == 8'h80 && b == 8'hFF) begin
      q = a; r = '0; lat = 1;
    end else if (sgn) begin
      q = N'($signed(a) / $signed(b));
      r = N'($signed(a) % $signed(b));
      lat = N + 2;
    end else begin
      q = a / b; r = a % b; lat = N + 2;
    end
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient_o, e.q);
        check("remainder", remainder_o, e.r);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke);
    exp_t e;
    int   lat;
    model(sgn, a, b, e.q, e.r, lat);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0; signed_i = 1'($urandom); dividend_i = N'($urandom); divisor_i = N'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      start_i = (poke && k == 2 && k < lat);
      @(negedge clk);
      check("busy", busy_o, 32'(k <= lat));
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    check("drained", sb.size(), 0);
    while (sb.size() != 0) void'(sb.pop_front());
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; kill_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    idle(3);
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_q", quotient_o, 0);
    check("rst_r", remainder_o, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed vectors with start pokes during busy on the first one.
    run_op(1'b0, 8'd100, 8'd7, 1'b1);
    check("q_100_7", quotient_o, 8'h0E);
    check("r_100_7", remainder_o, 8'h02);
    run_op(1'b1, 8'hF9, 8'h02, 1'b0);
    check("q_s_m7_2", quotient_o, 8'hFD);
    check("r_s_m7_2", remainder_o, 8'hFF);
    run_op(1'b0, 8'hF9, 8'h02, 1'b0);
    check("q_u_f9_2", quotient_o, 8'h7C);
    check("r_u_f9_2", remainder_o, 8'h01);
    run_op(1'b0, 8'h25, 8'h00, 1'b0);
    check("q_u_div0", quotient_o, 8'hFF);
    check("r_u_div0", remainder_o, 8'h25);
    run_op(1'b1, 8'h25, 8'h00, 1'b0);
    check("q_s_div0", quotient_o, 8'hFF);
    check("r_s_div0", remainder_o, 8'h25);
    run_op(1'b1, 8'h80, 8'hFF, 1'b0);
    check("q_s_ovf", quotient_o, 8'h80);
    check("r_s_ovf", remainder_o, 8'h00);
    run_op(1'b0, 8'h80, 8'hFF, 1'b1);
    check("q_u_80_ff", quotient_o, 8'h00);
    check("r_u_80_ff", remainder_o, 8'h80);

    // Kill in CALC at cycle 4: idle at cycle 5, no result, outputs held.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 8'd100; divisor_i = 8'd7;
    repeat (4) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    check("kill_busy", busy_o, 0);
    check("kill_q_held", quotient_o, last_q);
    check("kill_r_held", remainder_o, last_r);
    idle(12);
    run_op(1'b0, 8'd9, 8'd3, 1'b0);
    check("q_9_3", quotient_o, 8'h03);
    check("r_9_3", remainder_o, 8'h00);

    // Kill together with start in IDLE: nothing starts.
    @(posedge clk); #1;
    start_i = 1'b1; kill_i = 1'b1; dividend_i = 8'd50; divisor_i = 8'd5;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    check("kill_idle_busy", busy_o, 0);
    idle(12);

    // Kill during DONE is ignored: the special-case result still pulses.
    begin
      exp_t e;
      int   lat;
      model(1'b0, 8'h5A, 8'h00, e.q, e.r, lat);
      @(posedge clk); #1;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 8'h5A; divisor_i = 8'h00;
      e.cyc = cyc + lat;
      sb.push_back(e);
      @(posedge clk); #1;
      start_i = 1'b0; kill_i = 1'b1;
      @(negedge clk);
      check("kill_done_valid", valid_o, 1);
      @(posedge clk); #1;
      kill_i = 1'b0;
      idle(2);
      check("kill_done_drained", sb.size(), 0);
      while (sb.size() != 0) void'(sb.pop_front());
    end

    // Random operands in both modes, with occasional zero divisors.
    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      run_op(1'($urandom), a, b, 1'($urandom));
    end

    // Reset at cycle 3 mid-op, with a start poke while busy.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 8'hC3; divisor_i = 8'h05;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_q", quotient_o, 0);
    check("midrst_r", remainder_o, 0);
    idle(14);
    check("midrst_no_result", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
